lieat_ifu_bpu: RTL and testbench

Branch prediction unit on the IFU side: the responder for the commit unit's `prdt_*` resolution/flush interface. It holds a gshare table of 2-bit saturating counters and a global history register. It answers same-cycle taken/target lookups for fetched branches, tagging each with the table index used. It trains on resolved outcomes and forwards mispredict redirects to the PC generator, returning `flush_sh` to the commit unit.

---
 rtl/lieat_ifu_bpu.sv | 115 +++++++++++
 tb/tb_lieat_ifu_bpu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_ifu_bpu.sv
// Purpose : gshare branch predictor on the fetch side. It holds 2-bit counters and a global
//           history, trains on committed branch outcomes, and passes mispredict redirects through.
// Latency : 0-cycle lookup and redirect. Training becomes visible on the cycle after prdt_en.
// Backpressure: there is no buffering. flush_sh = prdt_flush & ifu_flush_ready, and the commit
//           unit holds prdt_flush and prdt_pc until flush_sh.
//
// Ports:
//   clock, reset                    rising-edge clock, synchronous active-high reset
//   ifu_req_valid/pc/bxx/jal/imm    fetch-side lookup request (combinational)
//   ifu_prdt_taken/pc/index         lookup response: taken, target (pc+imm), table index
//   prdt_en/index/res               training pulse from commit (resolved conditional branch)
//   prdt_flush/prdt_pc -> flush_sh  redirect request from commit and its acceptance
//   ifu_flush_valid/pc/ready        redirect towards the PC generator
module lieat_ifu_bpu #(
    parameter int BHT_IDX = 5,
    parameter int XLEN    = 32
) (
    input  logic                clock,
    input  logic                reset,
    // lookup
    input  logic                ifu_req_valid,
    input  logic [XLEN-1:0]     ifu_req_pc,
    input  logic                ifu_req_bxx,
    input  logic                ifu_req_jal,
    input  logic [XLEN-1:0]     ifu_req_imm,
    output logic                ifu_prdt_taken,
    output logic [XLEN-1:0]     ifu_prdt_pc,
    output logic [BHT_IDX-1:0]  ifu_prdt_index,
    // training / redirect from commit
    input  logic                prdt_en,
    input  logic [BHT_IDX-1:0]  prdt_index,
    input  logic                prdt_res,
    input  logic                prdt_flush,
    input  logic [XLEN-1:0]     prdt_pc,
    output logic                flush_sh,
    // redirect to PC generator
    output logic                ifu_flush_valid,
    output logic [XLEN-1:0]     ifu_flush_pc,
    input  logic                ifu_flush_ready
);

    localparam int BHT_N = 1 << BHT_IDX;

    logic [1:0]         bht_q [BHT_N];
    logic [1:0]         bht_d [BHT_N];
    logic [BHT_IDX-1:0] ghr_q;
    logic [BHT_IDX-1:0] ghr_d;

    logic [BHT_IDX-1:0] lkp_idx;
    logic [1:0]         lkp_cnt;
    logic [1:0]         upd_cnt;

    // PC bits outside the index window do not take part in the hash.
    logic               unused_pc_bits;
    assign unused_pc_bits = ^{ifu_req_pc[XLEN-1:BHT_IDX+2], ifu_req_pc[1:0]};

    // ------------------------------------------------------------------
    // Lookup: reads flops only, so a same-cycle update to the same entry
    // is not seen until the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        lkp_idx        = ifu_req_pc[BHT_IDX+1:2] ^ ghr_q;
        lkp_cnt        = bht_q[lkp_idx];
        ifu_prdt_index = lkp_idx;
        ifu_prdt_pc    = ifu_req_pc + ifu_req_imm;
        // A pending redirect makes the current fetch stream stale, so no
        // taken prediction is issued while it is outstanding.
        ifu_prdt_taken = ifu_req_valid & ~ifu_flush_valid
                       & (ifu_req_jal | (ifu_req_bxx & lkp_cnt[1]));
    end

    // ------------------------------------------------------------------
    // Redirect passthrough
    // ------------------------------------------------------------------
    always_comb begin
        ifu_flush_valid = prdt_flush;
        ifu_flush_pc    = prdt_pc;
        flush_sh        = prdt_flush & ifu_flush_ready;
    end

    // ------------------------------------------------------------------
    // Training: saturating counter update plus a history shift. The history
    // only advances at commit, so nothing needs restoring on a flush.
    // ------------------------------------------------------------------
    always_comb begin
        bht_d   = bht_q;
        ghr_d   = ghr_q;
        upd_cnt = bht_q[prdt_index];
        if (prdt_en) begin
            if (prdt_res) begin
                if (upd_cnt != 2'b11) begin
                    bht_d[prdt_index] = upd_cnt + 2'b01;
                end
            end else begin
                if (upd_cnt != 2'b00) begin
                    bht_d[prdt_index] = upd_cnt - 2'b01;
                end
            end
            ghr_d = {ghr_q[BHT_IDX-2:0], prdt_res};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
            ghr_q <= '0;
        end else begin
            bht_q <= bht_d;
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: tb/tb_lieat_ifu_bpu.sv
// Purpose : self-checking bench for lieat_ifu_bpu, with directed scenarios and a randomized run
//           checked against a table/history model.
// Latency : lookups and redirects are checked in the cycle they are driven, and training in the next cycle.
// Backpressure: the redirect is held until flush_sh, and ifu_flush_ready is randomized.
module tb_lieat_ifu_bpu;

    localparam int BI = 5;
    localparam int XL = 32;
    localparam int NE = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ifu_req_valid = 1'b0;
    logic [XL-1:0] ifu_req_pc = '0;
    logic          ifu_req_bxx = 1'b0;
    logic          ifu_req_jal = 1'b0;
    logic [XL-1:0] ifu_req_imm = '0;
    logic          ifu_prdt_taken;
    logic [XL-1:0] ifu_prdt_pc;
    logic [BI-1:0] ifu_prdt_index;
    logic          prdt_en = 1'b0;
    logic [BI-1:0] prdt_index = '0;
    logic          prdt_res = 1'b0;
    logic          prdt_flush = 1'b0;
    logic [XL-1:0] prdt_pc = '0;
    logic          flush_sh;
    logic          ifu_flush_valid;
    logic [XL-1:0] ifu_flush_pc;
    logic          ifu_flush_ready = 1'b0;

    always #5 clock = ~clock;

    lieat_ifu_bpu #(.BHT_IDX(BI), .XLEN(XL)) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_pc     (ifu_req_pc),
        .ifu_req_bxx    (ifu_req_bxx),
        .ifu_req_jal    (ifu_req_jal),
        .ifu_req_imm    (ifu_req_imm),
        .ifu_prdt_taken (ifu_prdt_taken),
        .ifu_prdt_pc    (ifu_prdt_pc),
        .ifu_prdt_index (ifu_prdt_index),
        .prdt_en        (prdt_en),
        .prdt_index     (prdt_index),
        .prdt_res       (prdt_res),
        .prdt_flush     (prdt_flush),
        .prdt_pc        (prdt_pc),
        .flush_sh       (flush_sh),
        .ifu_flush_valid(ifu_flush_valid),
        .ifu_flush_pc   (ifu_flush_pc),
        .ifu_flush_ready(ifu_flush_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one integer counter per entry and the history as an integer.
    int mcnt [NE];
    int mghr;

    // Protocol checks on the stimulus itself.
    logic en_seen = 1'b0;
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(ifu_req_bxx && ifu_req_jal)) else $error("illegal stimulus: bxx and jal together");
        end
        if (reset || !prdt_flush) begin
            en_seen <= 1'b0;
        end else begin
            assert (!(prdt_en && en_seen)) else $error("illegal stimulus: prdt_en repeated during held flush");
            if (flush_sh)     en_seen <= 1'b0;
            else if (prdt_en) en_seen <= 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < NE; i++) mcnt[i] = 1;
        mghr = 0;
    endtask

    // Advance one clock: the model takes the edge, and inputs are then re-driven 1 time unit later.
    task automatic tick();
        int k;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else if (prdt_en) begin
            k = int'(prdt_index);
            if (prdt_res) mcnt[k] = (mcnt[k] >= 3) ? 3 : mcnt[k] + 1;
            else          mcnt[k] = (mcnt[k] <= 0) ? 0 : mcnt[k] - 1;
            mghr = (mghr * 2 + int'(prdt_res)) % NE;
        end
        #1;
    endtask

    function automatic int exp_idx(input logic [XL-1:0] pc);
        return (int'(pc[BI+1:2]) ^ mghr) % NE;
    endfunction

    function automatic logic exp_taken(input logic v, input logic b, input logic j,
                                       input logic fl, input logic [XL-1:0] pc);
        return v && !fl && (j || (b && mcnt[exp_idx(pc)] >= 2));
    endfunction

    // PC whose lookup lands on table entry e under the current model history.
    function automatic logic [XL-1:0] pc_for(input int e);
        logic [XL-1:0] p;
        p = 32'h8000_0000 | (XL'((e ^ mghr) % NE) << 2);
        return p;
    endfunction

    task automatic drive_idle();
        ifu_req_valid = 1'b0; ifu_req_pc = '0; ifu_req_bxx = 1'b0; ifu_req_jal = 1'b0;
        ifu_req_imm = '0; prdt_en = 1'b0; prdt_index = '0; prdt_res = 1'b0;
        prdt_flush = 1'b0; prdt_pc = '0; ifu_flush_ready = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic train(input int e, input logic r);
        prdt_en = 1'b1; prdt_index = BI'(e); prdt_res = r;
        tick();
        prdt_en = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL rst_taken: got %b want 0", ifu_prdt_taken); end
        n_cmp++; if (ifu_prdt_pc !== '0) begin n_bad++; $display("FAIL rst_target: got %h want 0", ifu_prdt_pc); end
        n_cmp++; if (ifu_prdt_index !== '0) begin n_bad++; $display("FAIL rst_index: got %h want 0", ifu_prdt_index); end
        n_cmp++; if (ifu_flush_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_valid: got %b want 0", ifu_flush_valid); end
        n_cmp++; if (ifu_flush_pc !== '0) begin n_bad++; $display("FAIL rst_flush_pc: got %h want 0", ifu_flush_pc); end
        n_cmp++; if (flush_sh !== 1'b0) begin n_bad++; $display("FAIL rst_flush_sh: got %b want 0", flush_sh); end
    endtask

    task automatic test_lookup();
        do_reset();
        ifu_req_valid = 1'b1; ifu_req_pc = 32'h8000_0010; ifu_req_bxx = 1'b1; ifu_req_imm = 32'h20;
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'h04) begin n_bad++; $display("FAIL lk_index: got %h want 04", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL lk_taken_bxx: got %b want 0", ifu_prdt_taken); end
        n_cmp++; if (ifu_prdt_pc !== 32'h8000_0030) begin n_bad++; $display("FAIL lk_target: got %h want 80000030", ifu_prdt_pc); end
        ifu_req_bxx = 1'b0; ifu_req_jal = 1'b1;
        #1;
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL lk_taken_jal: got %b want 1", ifu_prdt_taken); end
        // A negative offset must wrap modulo 2^32.
        ifu_req_imm = 32'hFFFF_FFF0;
        #1;
        n_cmp++; if (ifu_prdt_pc !== 32'h8000_0000) begin n_bad++; $display("FAIL lk_target_neg: got %h want 80000000", ifu_prdt_pc); end
        drive_idle();
    endtask

    task automatic test_train_up();
        do_reset();
        train(4, 1'b1); train(4, 1'b1); train(4, 1'b1);
        ifu_req_valid = 1'b1; ifu_req_bxx = 1'b1; ifu_req_pc = 32'h8000_0000;
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'd7) begin n_bad++; $display("FAIL up_ghr_idx: got %h want 07", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL up_entry7: got %b want 0", ifu_prdt_taken); end
        ifu_req_pc = 32'h8000_000C;
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'd4) begin n_bad++; $display("FAIL up_idx4: got %h want 04", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL up_entry4: got %b want 1", ifu_prdt_taken); end
        // One not-taken from a saturated 11 must leave 10 (still taken); ghr becomes 01110.
        train(4, 1'b0);
        ifu_req_pc = 32'h8000_0028;
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'd4) begin n_bad++; $display("FAIL up_idx4b: got %h want 04", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL up_saturate: got %b want 1", ifu_prdt_taken); end
        drive_idle();
    endtask

    task automatic test_train_down();
        int want [4];
        want = '{1, 0, 0, 0};
        do_reset();
        train(9, 1'b1); train(9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            train(9, 1'b0);
            ifu_req_valid = 1'b1; ifu_req_bxx = 1'b1; ifu_req_pc = pc_for(9);
            #1;
            n_cmp++; if (ifu_prdt_index !== 5'd9) begin n_bad++; $display("FAIL dn_idx[%0d]: got %h want 09", k, ifu_prdt_index); end
            n_cmp++; if (ifu_prdt_taken !== want[k][0]) begin n_bad++; $display("FAIL dn_taken[%0d]: got %b want %0d", k, ifu_prdt_taken, want[k]); end
        end
        // Entry 9 now sits at 00: a single taken step must still predict not-taken.
        train(9, 1'b1);
        ifu_req_pc = pc_for(9);
        #1;
        n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL dn_floor: got %b want 0", ifu_prdt_taken); end
        drive_idle();
    endtask

    task automatic test_flush();
        do_reset();
        prdt_flush = 1'b1; prdt_pc = 32'h8000_1000; ifu_flush_ready = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_jal = 1'b1; ifu_req_pc = 32'h8000_0040; ifu_req_imm = 32'h100;
        for (int c = 0; c < 4; c++) begin
            ifu_flush_ready = (c == 3);
            #1;
            n_cmp++; if (ifu_flush_valid !== 1'b1) begin n_bad++; $display("FAIL fl_valid[%0d]: got %b want 1", c, ifu_flush_valid); end
            n_cmp++; if (ifu_flush_pc !== 32'h8000_1000) begin n_bad++; $display("FAIL fl_pc[%0d]: got %h want 80001000", c, ifu_flush_pc); end
            n_cmp++; if (flush_sh !== (c == 3)) begin n_bad++; $display("FAIL fl_sh[%0d]: got %b want %b", c, flush_sh, (c == 3)); end
            n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL fl_taken[%0d]: got %b want 0", c, ifu_prdt_taken); end
            tick();
        end
        prdt_flush = 1'b0; ifu_flush_ready = 1'b0;
        #1;
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL fl_release: got %b want 1", ifu_prdt_taken); end
        n_cmp++; if (ifu_flush_valid !== 1'b0) begin n_bad++; $display("FAIL fl_drop: got %b want 0", ifu_flush_valid); end
        drive_idle();
    endtask

    task automatic test_same_cycle();
        do_reset();
        ifu_req_valid = 1'b1; ifu_req_bxx = 1'b1; ifu_req_pc = 32'h8000_0014;
        prdt_en = 1'b1; prdt_index = 5'd5; prdt_res = 1'b1;
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'd5) begin n_bad++; $display("FAIL sc_idx: got %h want 05", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL sc_old: got %b want 0", ifu_prdt_taken); end
        tick();
        prdt_en = 1'b0;
        ifu_req_pc = 32'h8000_0010;   // ghr is now 1, so 4^1 = 5
        #1;
        n_cmp++; if (ifu_prdt_index !== 5'd5) begin n_bad++; $display("FAIL sc_idx_next: got %h want 05", ifu_prdt_index); end
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL sc_new: got %b want 1", ifu_prdt_taken); end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        int tr [6];
        tr = '{4, 4, 4, 9, 9, 17};
        do_reset();
        foreach (tr[i]) train(tr[i], 1'b1);
        prdt_flush = 1'b1; prdt_pc = 32'h8000_2000; ifu_flush_ready = 1'b0;
        tick();
        reset = 1'b1; prdt_en = 1'b1; prdt_index = 5'd3; prdt_res = 1'b1;
        tick();
        reset = 1'b0; prdt_en = 1'b0; prdt_flush = 1'b0;
        ifu_req_valid = 1'b1; ifu_req_bxx = 1'b1;
        for (int e = 0; e < NE; e++) begin
            ifu_req_pc = 32'h8000_0000 | (XL'(e) << 2);
            #1;
            n_cmp++; if (ifu_prdt_index !== BI'(e)) begin n_bad++; $display("FAIL rm_idx[%0d]: got %h want %h", e, ifu_prdt_index, BI'(e)); end
            n_cmp++; if (ifu_prdt_taken !== 1'b0) begin n_bad++; $display("FAIL rm_cnt[%0d]: got %b want 0", e, ifu_prdt_taken); end
        end
        // Counter back at 01: one taken step is enough to flip the prediction.
        train(4, 1'b1);
        ifu_req_pc = pc_for(4);
        #1;
        n_cmp++; if (ifu_prdt_taken !== 1'b1) begin n_bad++; $display("FAIL rm_weak: got %b want 1", ifu_prdt_taken); end
        drive_idle();
    endtask

    task automatic test_random();
        logic          fl_pend;
        logic          fl_start;
        logic [XL-1:0] fpc;
        logic          et;
        int            sel;
        do_reset();
        fl_pend = 1'b0; fpc = '0;
        for (int c = 0; c < 800; c++) begin
            sel           = int'($urandom_range(0, 2));
            ifu_req_valid = ($urandom_range(0, 3) != 0);
            ifu_req_bxx   = (sel == 1);
            ifu_req_jal   = (sel == 2);
            ifu_req_pc    = $urandom;
            ifu_req_imm   = $urandom;
            fl_start = 1'b0;
            if (!fl_pend && $urandom_range(0, 5) == 0) begin
                fl_pend = 1'b1; fl_start = 1'b1; fpc = $urandom;
            end
            prdt_flush      = fl_pend;
            prdt_pc         = fpc;
            ifu_flush_ready = ($urandom_range(0, 2) == 0);
            prdt_en         = (!fl_pend || fl_start) && ($urandom_range(0, 1) == 1);
            prdt_index      = BI'($urandom_range(0, NE - 1));
            prdt_res        = $urandom_range(0, 1) == 1;
            #1;
            et = exp_taken(ifu_req_valid, ifu_req_bxx, ifu_req_jal, fl_pend, ifu_req_pc);
            n_cmp++; if (ifu_prdt_index !== BI'(exp_idx(ifu_req_pc))) begin n_bad++; $display("FAIL rnd_idx[%0d]: got %h want %h", c, ifu_prdt_index, BI'(exp_idx(ifu_req_pc))); end
            n_cmp++; if (ifu_prdt_taken !== et) begin n_bad++; $display("FAIL rnd_taken[%0d]: got %b want %b", c, ifu_prdt_taken, et); end
            n_cmp++; if (ifu_prdt_pc !== ifu_req_pc + ifu_req_imm) begin n_bad++; $display("FAIL rnd_target[%0d]: got %h want %h", c, ifu_prdt_pc, ifu_req_pc + ifu_req_imm); end
            n_cmp++; if (ifu_flush_valid !== fl_pend) begin n_bad++; $display("FAIL rnd_fvalid[%0d]: got %b want %b", c, ifu_flush_valid, fl_pend); end
            n_cmp++; if (ifu_flush_pc !== fpc) begin n_bad++; $display("FAIL rnd_fpc[%0d]: got %h want %h", c, ifu_flush_pc, fpc); end
            n_cmp++; if (flush_sh !== (fl_pend && ifu_flush_ready)) begin n_bad++; $display("FAIL rnd_fsh[%0d]: got %b want %b", c, flush_sh, fl_pend && ifu_flush_ready); end
            tick();
            if (fl_pend && ifu_flush_ready) fl_pend = 1'b0;
        end
        drive_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lookup();
        test_train_up();
        test_train_down();
        test_flush();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
